// File: rtl/reg_bank_16x32_pkg.sv
// Shared types and constants for the architectural register bank, its read mux and decode.
package reg_bank_16x32_pkg;

   localparam int REG_WIDTH  = 32;
   localparam int REG_COUNT  = 16;
   localparam int REG_ADDR_W = 4;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [REG_WIDTH-1:0]  reg_word_t;

   // With a hardwired zero register, address 0 is neither written nor tracked.
   function automatic logic is_tracked(input reg_addr_t addr, input bit zero_r0);
      return !zero_r0 || (addr != '0);
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard: issue marks a destination busy, writeback retires it.
module reg_scoreboard
   import reg_bank_16x32_pkg::*;
#(
   parameter int NREGS   = REG_COUNT,
   parameter bit ZERO_R0 = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  iss_en,
   input  logic [REG_ADDR_W-1:0] iss_addr,
   input  logic                  wr_en,
   input  logic [REG_ADDR_W-1:0] wr_addr,
   input  logic [REG_ADDR_W-1:0] chk_sel,
   output logic [NREGS-1:0]      pending,
   output logic                  chk_busy,
   output logic                  wb_err
);

   logic [NREGS-1:0] pending_nxt;
   logic             wb_err_nxt;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      pending_nxt = pending;
      wb_err_nxt  = wb_err;
      if (wr_en && is_tracked(wr_addr, ZERO_R0)) begin
         pending_nxt[wr_addr] = 1'b0;
         if (!pending[wr_addr])
            wb_err_nxt = 1'b1;
      end
      // Applied last so a same-cycle issue beats the retiring writeback.
      if (iss_en && is_tracked(iss_addr, ZERO_R0))
         pending_nxt[iss_addr] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
         wb_err  <= 1'b0;
      end else begin
         pending <= pending_nxt;
         wb_err  <= wb_err_nxt;
      end
   end

   assign chk_busy = pending[chk_sel];

endmodule

// File: rtl/reg_bank_16x32.sv
// Sixteen-entry register bank feeding the 16-to-1 read mux, with pending-write scoreboard.
module reg_bank_16x32
   import reg_bank_16x32_pkg::*;
#(
   parameter int WIDTH   = REG_WIDTH,
   parameter int NREGS   = REG_COUNT,
   parameter bit ZERO_R0 = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [REG_ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  iss_en,
   input  logic [REG_ADDR_W-1:0] iss_addr,
   input  logic [REG_ADDR_W-1:0] chk_sel,
   output logic                  chk_busy,
   output logic [NREGS-1:0]      pending,
   output logic                  wb_err,
   output logic [WIDTH-1:0]      q0,
   output logic [WIDTH-1:0]      q1,
   output logic [WIDTH-1:0]      q2,
   output logic [WIDTH-1:0]      q3,
   output logic [WIDTH-1:0]      q4,
   output logic [WIDTH-1:0]      q5,
   output logic [WIDTH-1:0]      q6,
   output logic [WIDTH-1:0]      q7,
   output logic [WIDTH-1:0]      q8,
   output logic [WIDTH-1:0]      q9,
   output logic [WIDTH-1:0]      q10,
   output logic [WIDTH-1:0]      q11,
   output logic [WIDTH-1:0]      q12,
   output logic [WIDTH-1:0]      q13,
   output logic [WIDTH-1:0]      q14,
   output logic [WIDTH-1:0]      q15
);

   logic [WIDTH-1:0] regs [NREGS];

   // NOTE: the array is reset because every q output must read 0 right after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= '0;
      end else if (wr_en && is_tracked(wr_addr, ZERO_R0)) begin
         regs[wr_addr] <= wr_data;
      end
   end

   reg_scoreboard #(
      .NREGS   (NREGS),
      .ZERO_R0 (ZERO_R0)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .chk_sel  (chk_sel),
      .pending  (pending),
      .chk_busy (chk_busy),
      .wb_err   (wb_err)
   );

   assign q0  = ZERO_R0 ? '0 : regs[0];
   assign q1  = regs[1];
   assign q2  = regs[2];
   assign q3  = regs[3];
   assign q4  = regs[4];
   assign q5  = regs[5];
   assign q6  = regs[6];
   assign q7  = regs[7];
   assign q8  = regs[8];
   assign q9  = regs[9];
   assign q10 = regs[10];
   assign q11 = regs[11];
   assign q12 = regs[12];
   assign q13 = regs[13];
   assign q14 = regs[14];
   assign q15 = regs[15];

endmodule

// File: doc/reg_bank_16x32.md
Name: reg_bank_16x32

Overview:
- Sixteen-entry, 32-bit architectural register bank with a per-register pending-write scoreboard.
- Sits directly upstream of the 16-to-1 read mux. Outputs q0..q15 drive the mux data inputs; the mux select is driven by decode.
- The scoreboard tells the issue stage whether the register currently selected for reading still awaits a writeback.

Parameters:
- WIDTH, 32, data width of each register.
- NREGS, 16, register count; fixed to 16 to match the downstream mux.
- ZERO_R0, 1, when 1 register 0 always reads 0, and writes/issues to it are ignored.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  writeback strobe.
- wr_addr  input  4  writeback destination register.
- wr_data  input  WIDTH  writeback data.
- iss_en  input  1  instruction issue strobe; marks destination pending.
- iss_addr  input  4  destination register of the issued instruction.
- chk_sel  input  4  register index being read (same value fed to the mux select).
- chk_busy  output  1  pending bit of register chk_sel.
- pending  output  16  full scoreboard vector.
- wb_err  output  1  sticky flag: a writeback hit a non-pending register.
- q0..q15  output  WIDTH each  current register contents, to mux in0..in15.

Behaviour:
- Reset (rst=1 at a clock edge):
  - all registers, pending and wb_err become 0 at that edge.
  - rst has priority over wr_en and iss_en in the same cycle; the in-flight write is discarded.
- Write:
  - wr_en=1 → register[wr_addr] <= wr_data at the edge.
  - Visible on q outputs the next cycle; no write-through bypass, so latency is 1 cycle.
- Register 0 (ZERO_R0=1):
  - q0 is constant 0.
  - Writes to address 0 are dropped.
  - Issues to address 0 never set pending[0].
  - Writes to address 0 never set wb_err.
- Scoreboard next state, per register i:
  - Set when iss_en and iss_addr==i.
  - Else cleared when wr_en and wr_addr==i.
  - Else held.
- Simultaneous issue and writeback to the same register: the data is written and pending stays 1. The newer producer wins.
- Simultaneous issue and writeback to different registers: both take effect independently.
- Re-issue to an already-pending register: pending stays 1; no error.
- wb_err:
  - Set at the edge when wr_en=1, wr_addr is non-zero (or any address if ZERO_R0=0), and pending[wr_addr]=0 before that edge.
  - The write is still performed.
  - Cleared only by rst.
- chk_busy = pending[chk_sel], purely combinational from registered state. It does not look ahead at the same-cycle wr_en.
- pending output is the registered vector directly.
- No other state. All outputs are 0 immediately after reset.

Decomposition:
- Shared package holds:
  - constants REG_WIDTH=32, REG_COUNT=16, REG_ADDR_W=4;
  - type reg_addr_t (4-bit) and reg_word_t (32-bit), reused by the mux and decode.
- One sub-module: reg_scoreboard.
  - Inputs: clk, rst, iss_en/iss_addr, wr_en/wr_addr, chk_sel.
  - Outputs: pending, chk_busy, wb_err.
- The data array and write decode stay in the top module.

Test Plan:
- Reset: write R5=0xDEADBEEF, then assert rst for 1 cycle → q0..q15 all 0, pending=0x0000, wb_err=0.
- Issue/writeback: iss_en, iss_addr=3 → next cycle pending=0x0008 and chk_busy=1 with chk_sel=3. Then wr_en, wr_addr=3, wr_data=0x12345678 → next cycle q3=0x12345678, pending=0x0000.
- Same-cycle issue and writeback on R7, with R7 pending and wr_data=0xA5A5A5A5 → q7=0xA5A5A5A5, pending[7] still 1, wb_err=0.
- R0 protection: iss to 0, then wr_en addr 0 data 0xFFFFFFFF → q0=0, pending[0]=0, wb_err=0.
- Spurious writeback: wr_en addr 9 with pending[9]=0, data 0x00000042 → q9=0x42, wb_err=1 and it stays 1 until rst.
- Reset mid-operation: rst, wr_en (addr 2) and iss_en (addr 4) all in the same cycle → q2=0, pending=0x0000 after that edge.
